// File: rtl/uart_word_tx.sv
// ---------------------------------------------------------------------------
// uart_word_tx
//   Word-level UART transmitter. 32-bit words are pushed through a
//   valid/ready handshake into a small FIFO and each word is sent as four
//   8N1 bytes (least-significant byte first), matching the IM/DM loader
//   that reassembles four bytes, LSB byte first, into one RAM word.
//
// Optional feature:
//   UART_WORD_TX_PARITY_EN  when defined, an even-parity bit follows the
//                           8 data bits of every byte (8E1 framing).
//
// Parameters:
//   CLKS_PER_BIT    clock cycles per bit time (2..65535)
//   FIFO_DEPTH_BIT  FIFO holds 2**FIFO_DEPTH_BIT words
//   GAP_BITS        idle bit times appended after each stop bit (0..15)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   word_valid  word_data is valid this cycle
//   word_data   word to transmit
//   word_ready  FIFO can accept a word (low while rst is high)
//   Tx_Serial   registered UART line, idle high
//   busy        frame on the line or FIFO non-empty
//   fifo_level  number of buffered words
// ---------------------------------------------------------------------------
module uart_word_tx #(
    parameter logic [15:0] CLKS_PER_BIT   = 16'd10417,
    parameter int          FIFO_DEPTH_BIT = 2,
    parameter int          GAP_BITS       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    word_valid,
    input  logic [31:0]             word_data,
    output logic                    word_ready,
    output logic                    Tx_Serial,
    output logic                    busy,
    output logic [FIFO_DEPTH_BIT:0] fifo_level
);

    localparam int                      DEPTH      = 1 << FIFO_DEPTH_BIT;
    localparam logic [15:0]             BAUD_LAST  = CLKS_PER_BIT - 16'd1;
    // Only meaningful when GAP_BITS > 0; the GAP state is unreachable otherwise.
    localparam logic [3:0]              GAP_LAST   = 4'(GAP_BITS - 1);
    localparam logic [FIFO_DEPTH_BIT:0] LEVEL_FULL = (FIFO_DEPTH_BIT + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_BIT:0] LEVEL_ONE  = (FIFO_DEPTH_BIT + 1)'(1);
    localparam logic [FIFO_DEPTH_BIT-1:0] PTR_ONE  = FIFO_DEPTH_BIT'(1);

`ifdef UART_WORD_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;
`endif

    state_t                    state_q, state_d;
    logic [15:0]               baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [3:0]                gap_q, gap_d;
    logic [1:0]                byte_q, byte_d;
    logic [31:0]               shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic [FIFO_DEPTH_BIT-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_BIT:0]   level_q, level_d;
    logic [31:0]               fifo_mem [DEPTH];

    logic                      push;
    logic                      pop;
    logic                      bit_end;
    logic                      byte_done;
    logic [7:0]                byte_cur;

    assign word_ready = ~rst && (level_q < LEVEL_FULL);
    assign push       = word_valid && word_ready;
    assign bit_end    = (baud_q == BAUD_LAST);
    assign busy       = (state_q != S_IDLE) || (level_q != '0);
    assign fifo_level = level_q;
    assign Tx_Serial  = tx_q;

    // FIFO storage is tiny, so it is read asynchronously: the popped word
    // must land in the shift register on the same edge as the pop.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= word_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        byte_done = 1'b0;

        case (state_q)
            S_IDLE: begin
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_WORD_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (GAP_BITS == 0) begin
                        byte_done = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = 4'd0;
                    end
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    if (gap_q == GAP_LAST) begin
                        byte_done = 1'b1;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
        end

        // End of a byte frame: byte counter wraps 3 -> 0 at end of word.
        if (byte_done) begin
            byte_d = byte_q + 2'd1;
            if (byte_q != 2'd3) begin
                shift_d = {8'd0, shift_q[31:8]};
                state_d = S_START;
            end else begin
                state_d = S_IDLE;
            end
        end

        // Pop from IDLE, or straight from the last stop/gap bit so queued
        // words follow each other with no idle cycle in between.
        if (((state_q == S_IDLE) || (byte_done && (byte_q == 2'd3))) && (level_q != '0)) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            byte_d  = 2'd0;
            bit_d   = 3'd0;
            state_d = S_START;
        end

        // Line value for the state being entered, so Tx_Serial is a register.
        byte_cur = shift_d[7:0];
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = byte_cur[bit_d];
`ifdef UART_WORD_TX_PARITY_EN
            S_PARITY: tx_d = ^byte_cur;
`endif
            default:  tx_d = 1'b1;
        endcase

        case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            gap_q    <= 4'd0;
            byte_q   <= 2'd0;
            shift_q  <= 32'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            level_q  <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

    localparam int CPB = 4;
`ifdef UART_WORD_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int WORD_CYC   = 4 * FB * CPB;
    localparam int WORD_CYC_G = 4 * (FB + 2) * CPB;

    logic        clk;
    logic        rst;
    logic        valid, valid_g;
    logic [31:0] data, data_g;
    logic        ready, ready_g;
    logic        tx, tx_g;
    logic        busy, busy_g;
    logic [2:0]  level, level_g;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    uart_word_tx #(.CLKS_PER_BIT(16'd4), .FIFO_DEPTH_BIT(2), .GAP_BITS(0)) dut (
        .clk(clk), .rst(rst), .word_valid(valid), .word_data(data),
        .word_ready(ready), .Tx_Serial(tx), .busy(busy), .fifo_level(level)
    );

    uart_word_tx #(.CLKS_PER_BIT(16'd4), .FIFO_DEPTH_BIT(2), .GAP_BITS(2)) dut_g (
        .clk(clk), .rst(rst), .word_valid(valid_g), .word_data(data_g),
        .word_ready(ready_g), .Tx_Serial(tx_g), .busy(busy_g), .fifo_level(level_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Receiver model: waits (bounded) for a start bit, then samples every
    // cycle of four frames, checking each bit is held for exactly CPB cycles.
    // errs = -1 on timeout, otherwise the count of framing/timing errors.
    task automatic rx_word(input bit use_g, input int gap, output logic [31:0] w,
                           output logic [3:0] par, output int start_c, output int errs);
        int   nslots;
        int   waited;
        logic v;
        logic slot_v;
        logic [7:0] b;
        nslots  = FB + gap;
        w       = '0;
        par     = '0;
        errs    = 0;
        start_c = -1;
        waited  = 0;
        slot_v  = 1'b1;
        v = use_g ? tx_g : tx;
        while (v !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
            v = use_g ? tx_g : tx;
        end
        if (v !== 1'b0) begin
            errs = -1;
            return;
        end
        start_c = cyc;
        for (int by = 0; by < 4; by++) begin
            b = '0;
            for (int s = 0; s < nslots; s++) begin
                for (int k = 0; k < CPB; k++) begin
                    if (!(by == 0 && s == 0 && k == 0)) begin
                        @(negedge clk);
                        v = use_g ? tx_g : tx;
                    end
                    if (k == 0) slot_v = v;
                    else if (v !== slot_v) errs++;
                end
                if (s == 0) begin
                    if (slot_v !== 1'b0) errs++;
                end else if (s <= 8) begin
                    b[s-1] = slot_v;
`ifdef UART_WORD_TX_PARITY_EN
                end else if (s == 9) begin
                    par[by] = slot_v;
                    if (slot_v !== ^b) errs++;
`endif
                end else begin
                    if (slot_v !== 1'b1) errs++;
                end
            end
            w[by*8 +: 8] = b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
        tests++; if (tx_g !== 1'b1) begin fails++; $display("FAIL reset_tx_gap: got %b expected 1", tx_g); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", ready); end
        $display("[TB] reset done");
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        logic [3:0]  p;
        int s, e, n;
        data = 32'h44332211; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; n = cyc;
        tests++; if (level !== 3'd1) begin fails++; $display("FAIL single_level: got %0d expected 1", level); end
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL single_tx_idle: got %b expected 1", tx); end
        rx_word(1'b0, 0, w, p, s, e);
        tests++; if (s !== n + 1) begin fails++; $display("FAIL single_start: got cycle %0d expected %0d", s, n + 1); end
        tests++; if (w !== 32'h44332211) begin fails++; $display("FAIL single_data: got %h expected 44332211", w); end
        tests++; if (e !== 0) begin fails++; $display("FAIL single_frame: got %0d errors expected 0", e); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_last: got %b expected 1", busy); end
        @(negedge clk);
        tests++; if (busy !== 1'b0 || tx !== 1'b1) begin fails++; $display("FAIL single_end: got busy %b tx %b at cycle %0d expected 0/1 at %0d", busy, tx, cyc, n + 1 + WORD_CYC); end
        $display("[TB] single word %h start %0d", w, s);
    endtask

    task automatic test_fifo_full();
        logic [31:0] wl [6];
        logic [31:0] got [6];
        int acc [6];
        int st [6];
        int er [6];
        wl[0] = 32'hA0A1A2A3; wl[1] = 32'h0F1E2D3C; wl[2] = 32'hDEADBEEF;
        wl[3] = 32'h12345678; wl[4] = 32'hFFFF0000; wl[5] = 32'h80000001;
        for (int i = 0; i < 6; i++) begin acc[i] = -1; got[i] = '0; st[i] = -1; er[i] = -1; end
        fork
            begin
                int  idx;
                int  guard;
                bit  acc_now;
                bit  checked;
                idx = 0; guard = 0; checked = 1'b0;
                valid = 1'b1; data = wl[0];
                while (idx < 6 && guard < 1000) begin
                    acc_now = ready;
                    @(negedge clk);
                    guard++;
                    if (acc_now) begin
                        acc[idx] = cyc;
                        idx++;
                        if (idx < 6) data = wl[idx];
                        else valid = 1'b0;
                    end
                    if (idx == 5 && !checked) begin
                        checked = 1'b1;
                        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b expected 0", ready); end
                        tests++; if (level !== 3'd4) begin fails++; $display("FAIL full_level: got %0d expected 4", level); end
                    end
                end
                valid = 1'b0;
                tests++; if (idx != 6) begin fails++; $display("FAIL full_push_timeout: got %0d words accepted expected 6", idx); end
            end
            begin
                logic [3:0] pp;
                for (int i = 0; i < 6; i++) rx_word(1'b0, 0, got[i], pp, st[i], er[i]);
            end
        join
        for (int i = 1; i < 5; i++) begin
            tests++; if (acc[i] !== acc[0] + i) begin fails++; $display("FAIL full_accept_%0d: got cycle %0d expected %0d", i, acc[i], acc[0] + i); end
        end
        tests++; if (acc[5] !== acc[0] + WORD_CYC + 2) begin fails++; $display("FAIL full_accept_5: got cycle %0d expected %0d", acc[5], acc[0] + WORD_CYC + 2); end
        tests++; if (st[0] !== acc[0] + 1) begin fails++; $display("FAIL full_start_0: got cycle %0d expected %0d", st[0], acc[0] + 1); end
        for (int i = 0; i < 6; i++) begin
            tests++; if (got[i] !== wl[i] || er[i] !== 0) begin fails++; $display("FAIL full_word_%0d: got %h (%0d errors) expected %h", i, got[i], er[i], wl[i]); end
            if (i > 0) begin
                tests++; if (st[i] !== st[i-1] + WORD_CYC) begin fails++; $display("FAIL full_b2b_%0d: got start %0d expected %0d", i, st[i], st[i-1] + WORD_CYC); end
            end
            $display("[TB] fifo word %0d %h start %0d", i, got[i], st[i]);
        end
        @(negedge clk);
        tests++; if (busy !== 1'b0 || level !== 3'd0) begin fails++; $display("FAIL full_drain: got busy %b level %0d expected 0/0", busy, level); end
    endtask

    task automatic test_gap();
        logic [31:0] w;
        logic [3:0]  p;
        int s, e, n;
        data_g = 32'h5A3C0FF0; valid_g = 1'b1;
        @(negedge clk);
        valid_g = 1'b0; n = cyc;
        rx_word(1'b1, 2, w, p, s, e);
        tests++; if (s !== n + 1) begin fails++; $display("FAIL gap_start: got cycle %0d expected %0d", s, n + 1); end
        tests++; if (w !== 32'h5A3C0FF0 || e !== 0) begin fails++; $display("FAIL gap_data: got %h (%0d errors) expected 5a3c0ff0", w, e); end
        tests++; if (busy_g !== 1'b1) begin fails++; $display("FAIL gap_busy_last: got %b expected 1", busy_g); end
        @(negedge clk);
        tests++; if (busy_g !== 1'b0 || cyc !== s + WORD_CYC_G) begin fails++; $display("FAIL gap_len: got busy %b at cycle %0d expected 0 at %0d", busy_g, cyc, s + WORD_CYC_G); end
        $display("[TB] gap word %h start %0d", w, s);
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        logic [3:0]  p;
        int s, e, n, target;
        valid = 1'b1; data = 32'h44332211;
        @(negedge clk);
        n = cyc; data = 32'h55667788;
        @(negedge clk);
        data = 32'h99AABBCC;
        @(negedge clk);
        valid = 1'b0;
        // byte 1 (0x22) data bit 0 is a 0 on the line
        target = n + 1 + FB * CPB + CPB + 1;
        while (cyc < target) @(negedge clk);
        tests++; if (tx !== 1'b0 || level !== 3'd2) begin fails++; $display("FAIL mid_before: got tx %b level %0d expected 0/2", tx, level); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_tx: got %b expected 1", tx); end
        tests++; if (level !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL mid_flush: got level %0d busy %b expected 0/0", level, busy); end
        rst = 1'b0;
        @(negedge clk);
        data = 32'hCAFEF00D; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; n = cyc;
        rx_word(1'b0, 0, w, p, s, e);
        tests++; if (w !== 32'hCAFEF00D || e !== 0 || s !== n + 1) begin fails++; $display("FAIL mid_after: got %h (%0d errors) start %0d expected cafef00d start %0d", w, e, s, n + 1); end
        @(negedge clk);
        tests++; if (busy !== 1'b0 || tx !== 1'b1) begin fails++; $display("FAIL mid_no_stale: got busy %b tx %b expected 0/1", busy, tx); end
        $display("[TB] reset-mid recovered word %h", w);
    endtask

    task automatic test_parity();
        logic [31:0] w;
        logic [3:0]  p;
        int s, e, n;
        data = 32'h00000307; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; n = cyc;
        rx_word(1'b0, 0, w, p, s, e);
        tests++; if (w !== 32'h00000307 || e !== 0) begin fails++; $display("FAIL parity_data: got %h (%0d errors) expected 00000307", w, e); end
`ifdef UART_WORD_TX_PARITY_EN
        tests++; if (p !== 4'b0001) begin fails++; $display("FAIL parity_bits: got %b expected 0001", p); end
`endif
        @(negedge clk);
        tests++; if (busy !== 1'b0 || cyc !== s + WORD_CYC) begin fails++; $display("FAIL parity_len: got busy %b at cycle %0d expected 0 at %0d", busy, cyc, s + WORD_CYC); end
        $display("[TB] parity word %h parity %b start %0d", w, p, s);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; valid_g = 1'b0; data = '0; data_g = '0;
        test_reset();
        test_single_word();
        test_fifo_full();
        test_gap();
        test_reset_mid();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Word-level UART transmitter: accepts 32-bit words through a valid/ready handshake, buffers them in a small FIFO and serialises each word as four 8N1 bytes, least-significant byte first. This is the sending end of the word-over-UART loading protocol used by the on-board IM/DM loader, which reassembles four bytes, LSB byte first, into one RAM word. It contains its own bit serialiser and does not instantiate the existing uart_tx.

## Interface
- CLKS_PER_BIT, 16'd10417: clock cycles per bit time (100 MHz / 9600). Legal range 2..65535.
- FIFO_DEPTH_BIT, 2: FIFO depth is 2**FIFO_DEPTH_BIT words.
- GAP_BITS, 0: idle bit times inserted after each stop bit. Legal range 0..15.

Ports (clock and reset first):
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- word_valid  in  1  word_data is valid this cycle.
- word_data  in  32  word to transmit.
- word_ready  out  1  FIFO can accept a word. Equals ~rst && (fifo_level < 2**FIFO_DEPTH_BIT).
- Tx_Serial  out  1  UART line. Idle high. Registered.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  out  FIFO_DEPTH_BIT+1  number of words currently buffered.

## Operation
- **Push:** a word is accepted on any rising edge where word_valid && word_ready.
  - There is no bypass path; every word goes through the FIFO.
  - When the FIFO is full, word_ready is low, so a push is refused even if a pop happens in the same cycle.
- **Pop:** happens when the serialiser is in IDLE and fifo_level != 0.
  - The popped word is loaded into a 32-bit shift register and the byte counter is cleared.
  - A push and a pop in the same cycle are legal; fifo_level stays unchanged.
- **Serialiser FSM:** IDLE → START → DATA → [PARITY] → STOP → [GAP] → next state.
  - START: Tx_Serial = 0.
  - DATA: 8 bits, LSB first.
  - STOP: Tx_Serial = 1.
  - GAP: Tx_Serial = 1 for GAP_BITS bit times. The state is skipped when GAP_BITS = 0.
  - After STOP/GAP: if the byte counter is below 3, increment it, shift the word right by 8 and go to START. Otherwise go to IDLE.
- **Counters:**
  - Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1, reloads to 0 on every bit boundary.
  - Bit counter: 3 bits.
  - Byte counter: 2 bits. Its wrap from 3 to 0 marks the end of the word.
- **Pointers:** FIFO read and write pointers are FIFO_DEPTH_BIT bits wide and wrap naturally. Full and empty are derived from fifo_level only.
- **Reset values:** Tx_Serial=1, busy=0, fifo_level=0, word_ready=0 while rst is high. FSM returns to IDLE and all counters and pointers return to 0.
- **Reset mid-frame:** the frame is truncated, Tx_Serial is 1 on the edge after rst is sampled, and FIFO contents are discarded.

## Timing
- Word accepted at edge N, FIFO previously empty, serialiser idle: the pop and Tx_Serial falling to 0 both happen at edge N+1.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- Byte frame length: (10 + GAP_BITS) × CLKS_PER_BIT cycles, or 11 + GAP_BITS bit times with parity.
- Word length: 4 × byte frame length.
- Words queued back to back are sent with no extra idle: the next start bit immediately follows the last stop/gap bit.
- busy falls on the edge that ends the final stop/gap bit, provided the FIFO is empty.

## Configuration
- Macro: UART_WORD_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and transmits the even-parity bit (XOR of the 8 data bits) for one bit time. Frames are 11 bits plus the gap. The receiving end must be configured to match.
- Undefined: the PARITY state and its logic are not compiled; frames are pure 8N1.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH_BIT=2, GAP_BITS=0 unless stated otherwise.

1. **Reset:** hold rst for 3 cycles → Tx_Serial=1, busy=0, fifo_level=0, word_ready=0. Release rst → word_ready=1 the next cycle.
2. **Single word:** push 0x44332211 at edge N.
   - Required: start bit from edge N+1, then bytes 0x11, 0x22, 0x33, 0x44. 0x11 appears on the line as 1,0,0,0,1,0,0,0.
   - Line returns idle and busy falls at edge N+161.
3. **FIFO full:** hold word_valid high for 6 consecutive cycles with distinct words.
   - Required: words 0–4 accepted, word 5 stalls (word_ready=0, fifo_level=4).
   - Word 5 is accepted on the first edge after word 0 completes (160 cycles after its start bit). All 6 words are transmitted in push order.
4. **Inter-byte gap:** set GAP_BITS=2 → line stays high for exactly 12 cycles (stop bit plus 8) between each stop and the next start. Word length is 192 cycles.
5. **Reset mid-byte:** assert rst during the DATA bits of byte 1 while 2 words are queued.
   - Required: Tx_Serial=1 the next edge, fifo_level=0.
   - A word pushed after reset is released transmits correctly.
6. **Parity (UART_WORD_TX_PARITY_EN defined):** push 0x00000307 → byte 0x07 has parity bit 1, byte 0x03 has parity bit 0, bytes 0x00 have parity bit 0. Word length is 176 cycles.
